seq_catch_sched: RTL and testbench

Scheduler that shares one sequence-catcher instance (101 detector on a single tracked signal) among `N_CH` candidate signals, e.g. red/yellow/green of the traffic-light datapath. For each channel in turn it routes the signal to the catcher, arms the catcher, watches for `match` during a fixed window, and records the result. It sits between the light controller outputs and the catcher in the top-level CDC/FPV harness.

---
 rtl/seq_catch_sched.sv | 144 ++++++++++++++
 tb/tb_seq_catch_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_catch_sched.sv
// seq_catch_sched: time-shares one "101" sequence catcher among N_CH
// candidate signals. Each channel is routed to the catcher, armed, and
// watched for up to WIN_LEN enabled cycles. The result goes into hit_vec,
// and a saturating match counter is kept across passes.
// Optional build macro: SEQ_SCHED_CONTINUOUS_EN. When it is defined, start
// held high in DONE rolls straight into the next pass.
module seq_catch_sched #(
    parameter int N_CH    = 3,
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    en,
    input  logic [N_CH-1:0]         ch_sig,
    input  logic                    cat_match,
    output logic                    cat_start,
    output logic                    cat_en,
    output logic                    cat_tracked,
    output logic [$clog2(N_CH)-1:0] sel,
    output logic [N_CH-1:0]         hit_vec,
    output logic [CNT_W-1:0]        match_cnt,
    output logic                    busy,
    output logic                    done
);

    localparam int SEL_W = $clog2(N_CH);
    localparam int TMR_W = 8;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WATCH = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q;
    logic [SEL_W-1:0]  sel_q;
    logic [N_CH-1:0]   hit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [TMR_W-1:0]  tmr_q;

    logic [N_CH-1:0]   sel_onehot_d;
    logic [CNT_W-1:0]  cnt_d;

    // Saturating increment: the counter sticks once it reaches all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Compute the hit bit for the routed channel and the next match count.
    always_comb begin
        sel_onehot_d = N_CH'(1) << sel_q;
        cnt_d        = sat_inc(cnt_q);
    end

    // Scheduler FSM. en low freezes every register. Reset overrides both en and start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            hit_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
        end else if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ARM;
                        sel_q   <= '0;
                        hit_q   <= '0;
                        tmr_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ARM: begin
                    state_q <= S_WATCH;
                    tmr_q   <= '0;
                end
                S_WATCH: begin
                    tmr_q <= tmr_q + TMR_W'(1);
                    if (cat_match) begin
                        // Early exit. A match on the last window cycle still counts.
                        hit_q   <= hit_q | sel_onehot_d;
                        cnt_q   <= cnt_d;
                        state_q <= S_NEXT;
                    end else if (tmr_q == TMR_LAST) begin
                        state_q <= S_NEXT;
                    end else begin
                        state_q <= S_WATCH;
                    end
                end
                S_NEXT: begin
                    // The catcher is disabled in this state so its history flushes before the next channel.
                    if (sel_q == SEL_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        sel_q   <= sel_q + SEL_W'(1);
                        state_q <= S_ARM;
                    end
                end
                S_DONE: begin
`ifdef SEQ_SCHED_CONTINUOUS_EN
                    if (start) begin
                        state_q <= S_ARM;
                        sel_q   <= '0;
                        hit_q   <= '0;
                        tmr_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end else begin
            state_q <= state_q;
        end
    end

    // Outputs are decoded from registered state. The strobes are gated by en so a freeze silences them.
    assign cat_start   = en & (state_q == S_ARM);
    assign cat_en      = en & ((state_q == S_ARM) | (state_q == S_WATCH));
    assign done        = en & (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign sel         = sel_q;
    assign hit_vec     = hit_q;
    assign match_cnt   = cnt_q;
    assign cat_tracked = ch_sig[sel_q];

endmodule

// File: tb/tb_seq_catch_sched.sv
// Directed bench for seq_catch_sched.
// dut uses the default parameters. sat_dut uses CNT_W=2 and WIN_LEN=4 to reach counter saturation.
module tb_seq_catch_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, en, cat_match;
    logic [2:0] ch_sig;
    logic       cat_start, cat_en, cat_tracked, busy, done;
    logic [1:0] sel;
    logic [2:0] hit_vec;
    logic [7:0] match_cnt;

    logic       s_start, s_en, s_cat_match;
    logic [2:0] s_ch_sig;
    logic       s_cat_start, s_cat_en, s_cat_tracked, s_busy, s_done;
    logic [1:0] s_sel;
    logic [2:0] s_hit_vec;
    logic [1:0] s_match_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    seq_catch_sched #(.N_CH(3), .WIN_LEN(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .ch_sig(ch_sig),
        .cat_match(cat_match), .cat_start(cat_start), .cat_en(cat_en),
        .cat_tracked(cat_tracked), .sel(sel), .hit_vec(hit_vec),
        .match_cnt(match_cnt), .busy(busy), .done(done)
    );

    seq_catch_sched #(.N_CH(3), .WIN_LEN(4), .CNT_W(2)) sat_dut (
        .clk(clk), .rst(rst), .start(s_start), .en(s_en), .ch_sig(s_ch_sig),
        .cat_match(s_cat_match), .cat_start(s_cat_start), .cat_en(s_cat_en),
        .cat_tracked(s_cat_tracked), .sel(s_sel), .hit_vec(s_hit_vec),
        .match_cnt(s_match_cnt), .busy(s_busy), .done(s_done)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One pass of the main DUT. Called at a negedge while the DUT is in IDLE.
    // Channels set in hit_mask see the pattern 1,0,1 on the watched signal, then cat_match one cycle later.
    // If freeze_at is nonzero, en is dropped for 5 cycles once that many busy cycles have elapsed.
    task automatic run_pass(input logic [2:0] hit_mask, input int freeze_at,
                            output int nbusy, output int nstart, output int bad, output int got_done);
        int w;
        int frz;
        int frz_used;
        nbusy = 0; nstart = 0; bad = 0; got_done = 0; w = 0; frz = 0; frz_used = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (busy) nbusy++;
            if (done) begin
                got_done = 1;
                break;
            end
            if (cat_start) begin
                nstart++;
                w = 0;
            end
            ch_sig    = 3'b000;
            cat_match = 1'b0;
            if (en && cat_en && !cat_start) begin
                w++;
                if (hit_mask[sel]) begin
                    case (w)
                        1: ch_sig[sel] = 1'b1;
                        2: ch_sig[sel] = 1'b0;
                        3: ch_sig[sel] = 1'b1;
                        4: cat_match   = 1'b1;
                        default: cat_match = 1'b0;
                    endcase
                end
            end
            if (frz > 0) begin
                frz--;
                if (frz == 0) en = 1'b1;
            end else if (freeze_at > 0 && frz_used == 0 && nbusy == freeze_at) begin
                en = 1'b0;
                frz = 5;
                frz_used = 1;
            end
            #1;
            if (!en && (cat_en || cat_start || sel != 2'd0)) bad++;
            if (cat_tracked !== ch_sig[sel]) bad++;
            @(negedge clk);
        end
        ch_sig    = 3'b000;
        cat_match = 1'b0;
    endtask

    task automatic wait_done(output int n, output int idle_seen);
        n = 0; idle_seen = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            n++;
            if (!busy) idle_seen++;
            if (done) break;
        end
    endtask

    task automatic sat_pass(output int n);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        n = 1;
        for (int k = 0; k < 100; k++) begin
            if (s_done) break;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int nb, ns, bad, gd, n, idl, dcnt;
        rst = 1'b0; start = 1'b1; en = 1'b1; cat_match = 1'b0; ch_sig = 3'b000;
        s_start = 1'b0; s_en = 1'b1; s_cat_match = 1'b0; s_ch_sig = 3'b000;

        // Reset held for 3 cycles with start high
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_cat_start", {31'd0, cat_start}, 32'd0);
        check_val("rst_cat_en", {31'd0, cat_en}, 32'd0);
        check_val("rst_sel", {30'd0, sel}, 32'd0);
        check_val("rst_hit_vec", {29'd0, hit_vec}, 32'd0);
        check_val("rst_match_cnt", {24'd0, match_cnt}, 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check_val("idle_after_rst", {31'd0, busy}, 32'd0);

        // cat_match outside WATCH is ignored
        cat_match = 1'b1;
        repeat (2) @(negedge clk);
        cat_match = 1'b0;
        check_val("idle_match_cnt", {24'd0, match_cnt}, 32'd0);
        check_val("idle_hit_vec", {29'd0, hit_vec}, 32'd0);

        // Pass without matches: 3*(16+2)+1 = 55 busy cycles
        run_pass(3'b000, 0, nb, ns, bad, gd);
        check_val("nomatch_done", gd, 32'd1);
        check_val("nomatch_len", nb, 32'd55);
        check_val("nomatch_arms", ns, 32'd3);
        check_val("nomatch_mux", bad, 32'd0);
        check_val("nomatch_hit_vec", {29'd0, hit_vec}, 32'd0);
        check_val("nomatch_cnt", {24'd0, match_cnt}, 32'd0);
        @(negedge clk);
        check_val("nomatch_idle", {31'd0, busy}, 32'd0);
        check_val("done_one_cycle", {31'd0, done}, 32'd0);

        // Hit on channel 1: 18 + (1+4+1) + 18 + 1 = 43
        run_pass(3'b010, 0, nb, ns, bad, gd);
        check_val("hit1_len", nb, 32'd43);
        check_val("hit1_mux", bad, 32'd0);
        check_val("hit1_hit_vec", {29'd0, hit_vec}, 32'd2);
        check_val("hit1_cnt", {24'd0, match_cnt}, 32'd1);
        check_val("hit1_sel_hold", {30'd0, sel}, 32'd2);
        @(negedge clk);

        // Hits on channels 0 and 2: 6 + 18 + 6 + 1 = 31. hit_vec is cleared at start.
        run_pass(3'b101, 0, nb, ns, bad, gd);
        check_val("hit02_len", nb, 32'd31);
        check_val("hit02_hit_vec", {29'd0, hit_vec}, 32'd5);
        check_val("hit02_cnt", {24'd0, match_cnt}, 32'd3);
        @(negedge clk);

        // Freeze of 5 cycles inside channel 0 WATCH: 55 + 5 = 60
        run_pass(3'b000, 8, nb, ns, bad, gd);
        check_val("freeze_len", nb, 32'd60);
        check_val("freeze_outputs", bad, 32'd0);
        check_val("freeze_hit_vec", {29'd0, hit_vec}, 32'd0);
        check_val("freeze_cnt", {24'd0, match_cnt}, 32'd3);
        @(negedge clk);

        // start held high through DONE
        start = 1'b1;
        wait_done(n, idl);
        check_val("held_len", n, 32'd55);
`ifdef SEQ_SCHED_CONTINUOUS_EN
        wait_done(n, idl);
        check_val("cont_len", n, 32'd55);
        check_val("cont_busy_stays", idl, 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done(n, idl);
        check_val("cont_last_len", n, 32'd54);
        @(negedge clk);
        check_val("cont_idle", {31'd0, busy}, 32'd0);
`else
        @(negedge clk);
        check_val("held_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val("held_restart", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(n, idl);
        check_val("held_restart_len", n, 32'd54);
        @(negedge clk);
        check_val("held_final_idle", {31'd0, busy}, 32'd0);
`endif

        // Saturation on the 2-bit counter: each pass lasts 3*3+1 = 10 cycles
        s_cat_match = 1'b1;
        sat_pass(n);
        check_val("sat_len1", n, 32'd10);
        check_val("sat_cnt1", {30'd0, s_match_cnt}, 32'd3);
        @(negedge clk);
        sat_pass(n);
        check_val("sat_len2", n, 32'd10);
        check_val("sat_cnt2", {30'd0, s_match_cnt}, 32'd3);
        check_val("sat_hit_vec", {29'd0, s_hit_vec}, 32'd7);
        s_cat_match = 1'b0;
        @(negedge clk);

        // Reset in the middle of a pass aborts it without a done pulse
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_sel", {30'd0, sel}, 32'd0);
        check_val("abort_cnt", {24'd0, match_cnt}, 32'd0);
        dcnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check_val("abort_no_done", dcnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
